// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one pipelined main memory between the I-cache and D-cache
//             miss paths; serialises block fills and single-word writes.
//  Revision : 1.0
// ============================================================================
module cache_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  parameter int MEM_LAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic [DATA_W-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic                         i_fill_we,
  output logic                         d_fill_we,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(BLK_WORDS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int WORD_SH = $clog2(DATA_W / 8);
  localparam int OFF_W   = IDX_W + WORD_SH;
  localparam int TAG_W   = ADDR_W - OFF_W;

  if ((BLK_WORDS < 2) || ((BLK_WORDS & (BLK_WORDS - 1)) != 0)) begin : g_badBlkWords
    $error("BLK_WORDS must be a power of two");
  end
  if (MEM_LAT < 1) begin : g_badMemLat
    $error("MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state, w_nextState;
  logic               r_ownerD;
  logic               r_lastD;
  logic [TAG_W-1:0]   r_blkTag;
  logic [CNT_W-1:0]   r_issueCnt;
  logic [CNT_W-1:0]   r_retCnt;

  logic w_grantAny, w_grantD, w_issue, w_ret, w_lastRet, w_unused;

  // On a tie the side that was not served last wins.
  assign w_grantAny = i_req | d_req;
  assign w_grantD   = d_req & (~i_req | ~r_lastD);

  assign w_issue   = (r_state == S_FILL) && (r_issueCnt < CNT_W'(BLK_WORDS));
  assign w_ret     = (r_state == S_FILL) && mem_rvalid;
  assign w_lastRet = w_ret && (r_retCnt == CNT_W'(BLK_WORDS - 1));
  assign busy      = (r_state != S_IDLE);
  assign w_unused  = ^{i_addr[OFF_W-1:0], d_addr[WORD_SH-1:0]};

  always_comb begin
    w_nextState = r_state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grantAny) w_nextState = (w_grantD && d_wr) ? S_WRITE : S_FILL;
      end
      S_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {d_addr[ADDR_W-1:WORD_SH], {WORD_SH{1'b0}}};
        mem_wdata   = d_wdata;
        d_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      S_FILL: begin
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = {r_blkTag, r_issueCnt[IDX_W-1:0], {WORD_SH{1'b0}}};
        end
        // Returns run on their own counter; they overlap the issue phase.
        if (w_ret) begin
          fill_data = mem_rdata;
          fill_word = r_retCnt[IDX_W-1:0];
          i_fill_we = ~r_ownerD;
          d_fill_we = r_ownerD;
        end
        if (w_lastRet) begin
          i_done      = ~r_ownerD;
          d_done      = r_ownerD;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ownerD   <= 1'b0;
      r_lastD    <= 1'b0;
      r_blkTag   <= '0;
      r_issueCnt <= '0;
      r_retCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_grantAny) begin
            r_ownerD   <= w_grantD;
            r_blkTag   <= w_grantD ? d_addr[ADDR_W-1:OFF_W] : i_addr[ADDR_W-1:OFF_W];
            r_issueCnt <= '0;
            r_retCnt   <= '0;
          end
        end
        S_WRITE: r_lastD <= 1'b1;
        S_FILL: begin
          if (w_issue)   r_issueCnt <= r_issueCnt + 1'b1;
          if (w_ret)     r_retCnt   <= r_retCnt + 1'b1;
          if (w_lastRet) r_lastD    <= r_ownerD;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single pipelined main memory between the I-cache miss handler and the D-cache miss/write-through path. Serialises block fills (8 words) and single-word write-throughs, and streams returned words back to the granted cache with a word index. Resolves simultaneous requests with round-robin on ties. Sits between the two cache controllers and the unified memory model inside the CPU.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `BLK_WORDS`, 8: words per cache block. Must be a power of 2.
- `MEM_LAT`, 4: cycles from memory read issue to `mem_rvalid`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: I-cache block fill request. Held until `i_done`.
- `i_addr` in 16: I-miss address. Low 4 bits ignored.
- `d_req` in 1: D-cache request, fill or write. Held until `d_done`.
- `d_wr` in 1: with `d_req`, selects a single-word write-through instead of a fill.
- `d_addr` in 16: D address. Fill ignores low 4 bits; write ignores bit 0.
- `d_wdata` in 16: write-through data.
- `mem_en` out 1: memory access this cycle.
- `mem_wr` out 1: access is a write.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `fill_data` out 16: returned word, shared by both caches.
- `fill_word` out 3: word index within the block.
- `i_fill_we` out 1: I-cache write enable for `fill_data`.
- `d_fill_we` out 1: D-cache write enable for `fill_data`.
- `i_done` out 1: one-cycle pulse, I fill complete.
- `d_done` out 1: one-cycle pulse, D fill or write complete.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, FILL, WRITE.
- IDLE:
  - No request pending: stay in IDLE.
  - Only `d_req`: grant D.
  - Only `i_req`: grant I.
  - Both pending: grant the owner not served last. `last_d` is a register, reset 0, so D wins the first tie.
  - D grant with `d_wr`=1 → WRITE. Any other grant → FILL.
  - On grant, latch owner and base = `addr & ~16'hF`; clear `issue_cnt` and `ret_cnt`.
- WRITE, one cycle:
  - Drive `mem_en`=1, `mem_wr`=1, `mem_addr` = `d_addr & ~1`, `mem_wdata` = `d_wdata`.
  - `d_done`=1 in the same cycle; set `last_d`=1; next state IDLE.
- FILL:
  - While `issue_cnt` < 8: `mem_en`=1, `mem_wr`=0, `mem_addr` = base + 2·`issue_cnt`; increment `issue_cnt`.
  - Each `mem_rvalid`: `fill_data` = `mem_rdata`, `fill_word` = `ret_cnt`, owner's `fill_we`=1; increment `ret_cnt`.
  - Returns are counted independently of issues; they overlap issue cycles.
  - On the 8th return (`ret_cnt`=7 with `mem_rvalid`): assert the owner's done in the same cycle, update `last_d`, next state IDLE.
- `mem_rvalid` outside FILL is ignored: no `fill_we`, no counter change.
- Deasserting the owner's request mid-FILL does not cancel the fill; it runs to completion. A request held after its done pulse is treated as a new request in the next IDLE cycle.
- Non-owner requests are never dropped; they wait and are arbitrated in IDLE.

## Timing
- All outputs are 0 after reset, and all registers clear asynchronously.
- Reset during FILL or WRITE:
  - Go to IDLE.
  - Counters and `last_d` clear.
  - No done pulse.
  - Late `mem_rvalid` returns are dropped.
- Outputs are combinational from state/counters plus `mem_rvalid`/`mem_rdata`, and valid in the same cycle.
- Fill latency, with request first seen in IDLE at cycle 0:
  - Issues in cycles 1–8.
  - Returns in cycles 1+`MEM_LAT` through 8+`MEM_LAT` (5–12 by default).
  - done in cycle 12; IDLE in cycle 13.
  - A new grant is possible in cycle 13.
- Write latency: grant at cycle 0, write and `d_done` at cycle 1, IDLE at cycle 2.
- `fill_word` wraps naturally at 3 bits; `issue_cnt` and `ret_cnt` are 4 bits wide to represent 8.
- Address arithmetic is modulo 2^16. The base is aligned, so +14 never crosses a block boundary.

## Test plan
1. I fill only:
   - Stimulus: `i_req`=1, `i_addr`=0x123A; memory returns word k = 0xA000+k.
   - Required: `mem_addr` = 0x1230, 0x1232, …, 0x123E in cycles 1–8.
   - Required: `i_fill_we` in cycles 5–12 with `fill_word` 0–7.
   - Required: `i_done` in cycle 12; `d_fill_we` never asserted.
2. Tie round-robin:
   - Stimulus: `i_req` and `d_req` (fill) asserted together from reset, both held.
   - Required: D served first, I second, then D again. `d_done` and `i_done` alternate.
3. Write-through:
   - Stimulus: `d_req`=1, `d_wr`=1, `d_addr`=0x0045, `d_wdata`=0xBEEF.
   - Required: cycle 1 has `mem_en`=`mem_wr`=1, `mem_addr`=0x0044, `mem_wdata`=0xBEEF, `d_done`=1.
4. Request during fill:
   - Stimulus: `d_req` write raised at cycle 6 of an I fill.
   - Required: no memory write before I `i_done`; write issued in the cycle after the first post-fill IDLE grant.
5. Reset mid-fill:
   - Stimulus: assert `rst` at cycle 7 of a fill and release it; memory keeps returning.
   - Required: all outputs 0; no `fill_we` or done pulses; `busy`=0.
   - Required: the next `i_req` starts cleanly with `fill_word` 0.
6. Stray return:
   - Stimulus: `mem_rvalid`=1 while IDLE.
   - Required: no `fill_we`; the next fill returns `fill_word` starting at 0.
